// File: rtl/axi_rt_cfg_sequencer.sv
// rtl/axi_rt_cfg_sequencer.sv - staged IMTU budget/period commit sequencer
// One unit at a time: isolate, wait for drain, load, restart period, release.
module axi_rt_cfg_sequencer #(
    parameter int NumMgrs        = 4,
    parameter int NumAddrRegions = 2,
    parameter int BudgetWidth    = 32,
    parameter int PeriodWidth    = 32,
    parameter int TimeoutWidth   = 16
) (
    input  logic                                         clk_i,
    input  logic                                         rst_i,
    input  logic [NumMgrs-1:0]                           commit_i,
    input  logic [NumMgrs*NumAddrRegions*BudgetWidth-1:0] staged_w_budget_i,
    input  logic [NumMgrs*NumAddrRegions*PeriodWidth-1:0] staged_w_period_i,
    input  logic [NumMgrs*NumAddrRegions*BudgetWidth-1:0] staged_r_budget_i,
    input  logic [NumMgrs*NumAddrRegions*PeriodWidth-1:0] staged_r_period_i,
    output logic [NumMgrs*NumAddrRegions*BudgetWidth-1:0] w_budget_o,
    output logic [NumMgrs*NumAddrRegions*PeriodWidth-1:0] w_period_o,
    output logic [NumMgrs*NumAddrRegions*BudgetWidth-1:0] r_budget_o,
    output logic [NumMgrs*NumAddrRegions*PeriodWidth-1:0] r_period_o,
    output logic [NumMgrs-1:0]                           isolate_o,
    input  logic [NumMgrs-1:0]                           isolated_i,
    output logic [NumMgrs-1:0]                           imtu_abort_o,
    input  logic [TimeoutWidth-1:0]                      timeout_limit_i,
    output logic [NumMgrs-1:0]                           done_o,
    output logic [NumMgrs-1:0]                           timeout_o,
    input  logic [NumMgrs-1:0]                           clear_timeout_i,
    output logic                                         busy_o
);
    localparam int SelW  = (NumMgrs > 1) ? $clog2(NumMgrs) : 1;
    localparam int BSlcW = NumAddrRegions * BudgetWidth;
    localparam int PSlcW = NumAddrRegions * PeriodWidth;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISO,
        S_LOAD,
        S_TIMEOUT,
        S_RELEASE
    } state_t;

    state_t                  r_state, w_state_nxt;
    logic [SelW-1:0]         r_sel, r_rr, w_pick;
    logic                    w_pick_vld;
    logic [NumMgrs-1:0]      r_pending, r_timeout, w_pend_clr, w_sel_oh;
    logic [TimeoutWidth-1:0] r_wait_cnt;
    logic                    r_loaded;
    logic                    w_iso_ack, w_to_hit;
    int                      w_idx;
    logic [NumMgrs*BSlcW-1:0] r_w_budget, r_r_budget;
    logic [NumMgrs*PSlcW-1:0] r_w_period, r_r_period;

    assign w_sel_oh  = NumMgrs'(1) << r_sel;
    assign w_iso_ack = isolated_i[r_sel];
    assign w_to_hit  = (timeout_limit_i != '0) &&
                       (r_wait_cnt == timeout_limit_i - TimeoutWidth'(1));

    // Scan downward so the pending index closest to the rr pointer wins.
    always_comb begin
        w_pick     = r_rr;
        w_pick_vld = 1'b0;
        w_idx      = 0;
        for (int k = NumMgrs - 1; k >= 0; k--) begin
            w_idx = (int'(r_rr) + k) % NumMgrs;
            if (r_pending[w_idx]) begin
                w_pick     = SelW'(w_idx);
                w_pick_vld = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_pend_clr   = '0;
        isolate_o    = '0;
        imtu_abort_o = '0;
        done_o       = '0;
        case (r_state)
            S_IDLE: if (w_pick_vld) w_state_nxt = S_ISO;
            S_ISO: begin
                isolate_o = w_sel_oh;
                if (w_iso_ack) begin
                    w_state_nxt = S_LOAD;
                    w_pend_clr  = w_sel_oh;
                end else if (w_to_hit) begin
                    w_state_nxt = S_TIMEOUT;
                    w_pend_clr  = w_sel_oh;
                end
            end
            S_LOAD: begin
                isolate_o    = w_sel_oh;
                imtu_abort_o = w_sel_oh;
                w_state_nxt  = S_RELEASE;
            end
            S_TIMEOUT: w_state_nxt = S_RELEASE;
            S_RELEASE: begin
                if (!w_iso_ack) begin
                    w_state_nxt = S_IDLE;
                    if (r_loaded) done_o = w_sel_oh;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_sel      <= '0;
            r_rr       <= '0;
            r_pending  <= '0;
            r_timeout  <= '0;
            r_wait_cnt <= '0;
            r_loaded   <= 1'b0;
            r_w_budget <= '0;
            r_w_period <= '0;
            r_r_budget <= '0;
            r_r_period <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_pending <= (r_pending & ~w_pend_clr) | commit_i;
            r_timeout <= (r_timeout & ~clear_timeout_i) |
                         ((r_state == S_TIMEOUT) ? w_sel_oh : '0);
            if (r_state == S_IDLE && w_pick_vld) begin
                r_sel      <= w_pick;
                r_rr       <= (w_pick == SelW'(NumMgrs - 1)) ? '0 : w_pick + SelW'(1);
                r_wait_cnt <= '0;
                r_loaded   <= 1'b0;
            end
            if (r_state == S_ISO && r_wait_cnt != '1) r_wait_cnt <= r_wait_cnt + TimeoutWidth'(1);
            // Staged values are sampled only in the LOAD cycle, and only for sel.
            if (r_state == S_LOAD) begin
                r_loaded <= 1'b1;
                for (int m = 0; m < NumMgrs; m++) begin
                    if (SelW'(m) == r_sel) begin
                        r_w_budget[m*BSlcW +: BSlcW] <= staged_w_budget_i[m*BSlcW +: BSlcW];
                        r_w_period[m*PSlcW +: PSlcW] <= staged_w_period_i[m*PSlcW +: PSlcW];
                        r_r_budget[m*BSlcW +: BSlcW] <= staged_r_budget_i[m*BSlcW +: BSlcW];
                        r_r_period[m*PSlcW +: PSlcW] <= staged_r_period_i[m*PSlcW +: PSlcW];
                    end
                end
            end
        end
    end

    assign w_budget_o = r_w_budget;
    assign w_period_o = r_w_period;
    assign r_budget_o = r_r_budget;
    assign r_period_o = r_r_period;
    assign timeout_o  = r_timeout;
    assign busy_o     = (r_state != S_IDLE);

endmodule

// File: tb/tb_axi_rt_cfg_sequencer.sv
// tb/tb_axi_rt_cfg_sequencer.sv - bench for axi_rt_cfg_sequencer
// Procedural timeline model of each commit sequence, compared every cycle.
module tb_axi_rt_cfg_sequencer;
    localparam int N  = 4;
    localparam int VW = 256;

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic [N-1:0]  commit = '0, isolated = '0, clr_to = '0;
    logic [VW-1:0] swb = '0, swp = '0, srb = '0, srp = '0;
    logic [VW-1:0] wbo, wpo, rbo, rpo;
    logic [N-1:0]  iso, abort, done, tout;
    logic [15:0]   tlim = '0;
    logic          busy;

    axi_rt_cfg_sequencer dut (
        .clk_i(clk), .rst_i(rst_i), .commit_i(commit),
        .staged_w_budget_i(swb), .staged_w_period_i(swp),
        .staged_r_budget_i(srb), .staged_r_period_i(srp),
        .w_budget_o(wbo), .w_period_o(wpo), .r_budget_o(rbo), .r_period_o(rpo),
        .isolate_o(iso), .isolated_i(isolated), .imtu_abort_o(abort),
        .timeout_limit_i(tlim), .done_o(done), .timeout_o(tout),
        .clear_timeout_i(clr_to), .busy_o(busy)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    task automatic chk(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad < 40) $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Reference model: state held for the current cycle, advanced at each posedge.
    logic [N-1:0]  m_pend, m_to, m_iso, m_abort;
    logic          m_busy, m_rel, m_rel_load;
    int            m_sel, m_rr;
    logic [VW-1:0] m_wb, m_wp, m_rb, m_rp;

    task automatic m_reset();
        m_pend = '0; m_to = '0; m_iso = '0; m_abort = '0;
        m_busy = 0; m_rel = 0; m_rel_load = 0; m_sel = 0; m_rr = 0;
        m_wb = '0; m_wp = '0; m_rb = '0; m_rp = '0;
    endtask

    task automatic wait_edge(output bit r);
        @(posedge clk);
        r = rst_i;
        if (r) m_reset();
    endtask

    task automatic book(input logic [N-1:0] clr);
        m_pend = (m_pend & ~clr) | commit;
        m_to   = m_to & ~clear_timeout_mask();
    endtask

    function automatic logic [N-1:0] clear_timeout_mask();
        return clr_to;
    endfunction

    task automatic serve(input int sel);
        bit r;
        int cnt, outcome;
        m_rr = (sel + 1) % N; m_sel = sel; m_busy = 1; m_iso = N'(1 << sel);
        cnt = 0; outcome = 0;
        while (outcome == 0) begin
            wait_edge(r); if (r) return;
            if (isolated[sel]) begin outcome = 1; book(N'(1 << sel)); end
            else if (tlim != 0 && cnt == int'(tlim) - 1) begin outcome = 2; book(N'(1 << sel)); end
            else begin book('0); if (cnt < 65535) cnt++; end
        end
        if (outcome == 1) begin
            m_abort = N'(1 << sel);
            wait_edge(r); if (r) return;
            m_wb[sel*64 +: 64] = swb[sel*64 +: 64];
            m_wp[sel*64 +: 64] = swp[sel*64 +: 64];
            m_rb[sel*64 +: 64] = srb[sel*64 +: 64];
            m_rp[sel*64 +: 64] = srp[sel*64 +: 64];
            book('0);
            m_abort = '0; m_iso = '0; m_rel = 1; m_rel_load = 1;
        end else begin
            m_iso = '0;
            wait_edge(r); if (r) return;
            book('0);
            m_to[sel] = 1'b1;
            m_rel = 1; m_rel_load = 0;
        end
        forever begin
            bit ex;
            wait_edge(r); if (r) return;
            ex = !isolated[sel];
            book('0);
            if (ex) begin m_rel = 0; m_rel_load = 0; m_busy = 0; return; end
        end
    endtask

    initial begin : model
        bit r;
        logic [N-1:0] p;
        int pick;
        m_reset();
        forever begin
            wait_edge(r);
            if (!r) begin
                p = m_pend;
                book('0);
                if (p != 0) begin
                    pick = 0;
                    for (int k = N - 1; k >= 0; k--) if (p[(m_rr + k) % N]) pick = (m_rr + k) % N;
                    serve(pick);
                end
            end
        end
    end

    // Unit responder: isolated_i follows isolate_o after lag cycles unless stuck low.
    int           lag [N];
    logic [N-1:0] stuck = '0;
    logic [3:0]   hist [N];
    initial begin
        for (int m = 0; m < N; m++) begin lag[m] = 1; hist[m] = '0; end
        forever begin
            @(posedge clk); #2;
            for (int m = 0; m < N; m++) begin
                isolated[m] = stuck[m] ? 1'b0 : hist[m][lag[m]-1];
                hist[m] = {hist[m][2:0], iso[m]};
            end
        end
    end

    bit cmp_on = 0;
    int iso_cnt [N], abort_cnt [N], done_cnt [N];
    int order [$];
    initial begin @(posedge clk); #1 cmp_on = 1; end

    always @(negedge clk) begin
        logic [N-1:0] ed;
        if (cmp_on) begin
            ed = (m_rel && m_rel_load && !isolated[m_sel]) ? N'(1 << m_sel) : '0;
            chk("isolate", VW'(iso), VW'(m_iso));
            chk("abort", VW'(abort), VW'(m_abort));
            chk("done", VW'(done), VW'(ed));
            chk("timeout", VW'(tout), VW'(m_to));
            chk("busy", VW'(busy), VW'(m_busy));
            chk("w_budget", wbo, m_wb);
            chk("w_period", wpo, m_wp);
            chk("r_budget", rbo, m_rb);
            chk("r_period", rpo, m_rp);
            chk("one_isolated", VW'($countones(iso) <= 1), VW'(1));
            for (int m = 0; m < N; m++) begin
                iso_cnt[m] += int'(iso[m]);
                abort_cnt[m] += int'(abort[m]);
                done_cnt[m] += int'(done[m]);
                if (done[m]) order.push_back(m);
            end
        end
    end

    task automatic cyc(); @(posedge clk); #1; endtask

    task automatic clr_counts();
        for (int m = 0; m < N; m++) begin iso_cnt[m] = 0; abort_cnt[m] = 0; done_cnt[m] = 0; end
        order.delete();
    endtask

    task automatic do_rst();
        rst_i = 1; cyc(); cyc(); rst_i = 0; clr_counts();
    endtask

    task automatic pulse_commit(input logic [N-1:0] v);
        commit = v; cyc(); commit = '0;
    endtask

    task automatic wait_idle(input int maxc);
        int n = 0;
        while (!(busy == 0 && m_busy == 0 && m_pend == 0) && n < maxc) begin cyc(); n++; end
        if (n >= maxc) chk("idle_timeout", VW'(n), VW'(0));
        cyc(); cyc();
    endtask

    function automatic logic [VW-1:0] rnd256();
        logic [VW-1:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    logic [VW-1:0] saved, sp;
    int n;
    initial begin
        for (int m = 0; m < N; m++) begin iso_cnt[m] = 0; abort_cnt[m] = 0; done_cnt[m] = 0; end
        cyc(); cyc(); cyc();
        rst_i = 0;
        chk("rst_isolate", VW'(iso), VW'(0));
        chk("rst_busy", VW'(busy), VW'(0));
        chk("rst_wbudget", wbo, VW'(0));
        clr_counts();

        // Single commit on manager 1, one-cycle responder lag.
        swb = rnd256(); swp = rnd256(); srb = rnd256(); srp = rnd256();
        swb[64 +: 32] = 32'h100;
        sp = swp;
        pulse_commit(4'b0010);
        wait_idle(50);
        chk("t1_iso_cycles", VW'(iso_cnt[1]), VW'(3));
        chk("t1_abort", VW'(abort_cnt[1]), VW'(1));
        chk("t1_done", VW'(done_cnt[1]), VW'(1));
        chk("t1_wb_slice", VW'(wbo[64 +: 32]), VW'(32'h100));
        chk("t1_wb_others", {wbo[255:128], wbo[63:0]}, VW'(0));
        chk("t1_wp_slice", VW'(wpo[64 +: 64]), VW'(sp[64 +: 64]));

        // Three simultaneous commits from rr pointer 0.
        do_rst();
        pulse_commit(4'b1011);
        wait_idle(100);
        chk("t2_order_len", VW'(order.size()), VW'(3));
        if (order.size() == 3) begin
            chk("t2_order0", VW'(order[0]), VW'(0));
            chk("t2_order1", VW'(order[1]), VW'(1));
            chk("t2_order2", VW'(order[2]), VW'(3));
        end
        chk("t2_done3", VW'(done_cnt[3]), VW'(1));

        // Isolation timeout on manager 2.
        clr_counts();
        tlim = 16'd5; stuck = 4'b0100; saved = wbo;
        pulse_commit(4'b0100);
        wait_idle(50);
        chk("t3_iso_cycles", VW'(iso_cnt[2]), VW'(5));
        chk("t3_timeout", VW'(tout[2]), VW'(1));
        chk("t3_abort", VW'(abort_cnt[2]), VW'(0));
        chk("t3_done", VW'(done_cnt[2]), VW'(0));
        chk("t3_cfg", wbo, saved);
        clr_to = 4'b0100; cyc(); clr_to = '0; cyc();
        chk("t3_cleared", VW'(tout[2]), VW'(0));
        stuck = '0;

        // Unlimited wait on manager 0.
        clr_counts();
        tlim = '0; stuck = 4'b0001;
        pulse_commit(4'b0001);
        repeat (1000) cyc();
        chk("t4_still_busy", VW'(busy), VW'(1));
        chk("t4_no_timeout", VW'(tout[0]), VW'(0));
        stuck = '0;
        wait_idle(50);
        chk("t4_done", VW'(done_cnt[0]), VW'(1));

        // Re-commit during LOAD of manager 0; later staged value must win.
        clr_counts();
        swb[31:0] = 32'hAAAA_0001;
        pulse_commit(4'b0001);
        n = 0;
        while (!abort[0] && n < 50) begin cyc(); n++; end
        chk("t5_load_seen", VW'(abort[0]), VW'(1));
        commit = 4'b0001; cyc(); commit = '0;
        swb[31:0] = 32'hBBBB_0002;
        wait_idle(100);
        chk("t5_final", VW'(wbo[31:0]), VW'(32'hBBBB_0002));
        chk("t5_done2", VW'(done_cnt[0]), VW'(2));

        // Reset during ISO of manager 3.
        stuck = 4'b1000;
        pulse_commit(4'b1000);
        n = 0;
        while (!iso[3] && n < 20) begin cyc(); n++; end
        chk("t6_iso_seen", VW'(iso[3]), VW'(1));
        cyc(); cyc();
        rst_i = 1; cyc(); rst_i = 0;
        chk("t6_isolate", VW'(iso), VW'(0));
        chk("t6_busy", VW'(busy), VW'(0));
        chk("t6_cfg", wbo | wpo | rbo | rpo, VW'(0));
        repeat (5) cyc();
        chk("t6_no_pending", VW'(busy), VW'(0));
        stuck = '0;
        clr_counts();

        // Randomised traffic.
        tlim = 16'd6;
        for (int c = 0; c < 3000; c++) begin
            commit = ($urandom_range(0, 9) == 0) ? N'($urandom) : '0;
            clr_to = ($urandom_range(0, 19) == 0) ? N'($urandom) : '0;
            swb = rnd256(); swp = rnd256(); srb = rnd256(); srp = rnd256();
            if (c % 250 == 0) begin
                for (int m = 0; m < N; m++) lag[m] = $urandom_range(1, 3);
                stuck = N'($urandom & $urandom & $urandom);
            end
            cyc();
        end
        commit = '0; clr_to = '0; stuck = '0;
        wait_idle(500);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/axi_rt_cfg_sequencer.md
Name: axi_rt_cfg_sequencer

Overview:
- Applies staged IMTU budget/period configuration to NumMgrs real-time units safely.
- Per commit request: isolates the target unit, waits for drain, atomically loads new budget/period values, pulses the period abort to restart accounting, then de-isolates.
- Shared among all managers with round-robin arbitration; sits between the config register file and the per-manager RT units.

Parameters:
- NumMgrs, 4, number of RT units sequenced (>=1)
- NumAddrRegions, 2, regions per unit
- BudgetWidth, 32, budget field width
- PeriodWidth, 32, period field width
- TimeoutWidth, 16, isolation-wait timeout counter width

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- commit_i  in  NumMgrs  per-manager commit request, sampled each cycle (level or pulse)
- staged_w_budget_i  in  NumMgrs*NumAddrRegions*BudgetWidth  staged write budgets
- staged_w_period_i  in  NumMgrs*NumAddrRegions*PeriodWidth  staged write periods
- staged_r_budget_i  in  NumMgrs*NumAddrRegions*BudgetWidth  staged read budgets
- staged_r_period_i  in  NumMgrs*NumAddrRegions*PeriodWidth  staged read periods
- w_budget_o, w_period_o, r_budget_o, r_period_o  out  same widths  active config to the units
- isolate_o  out  NumMgrs  isolation request per unit
- isolated_i  in  NumMgrs  isolation status per unit
- imtu_abort_o  out  NumMgrs  one-cycle period-restart pulse
- timeout_limit_i  in  TimeoutWidth  max cycles to wait for isolated_i; 0 = wait forever
- done_o  out  NumMgrs  one-cycle pulse, sequence finished with config applied
- timeout_o  out  NumMgrs  sticky flag, isolation timed out, config not applied
- clear_timeout_i  in  NumMgrs  clears the matching timeout_o bit
- busy_o  out  1  FSM not in IDLE

Behaviour:
- Reset (synchronous on rst_i): state IDLE; pending, timeout_o, active config all 0; rr pointer 0.
- Reset outputs: isolate_o=0, imtu_abort_o=0, done_o=0, busy_o=0.
- Reset mid-sequence: releases isolate_o on the next edge; no partial load.
- pending[m] is set by commit_i[m] (registered). It is cleared when manager m enters LOAD or TIMEOUT. A simultaneous set and clear resolves to set, so m is serviced again.
- Arbitration in IDLE with pending!=0:
  - Select the first pending index at or after the rr pointer, wrapping modulo NumMgrs.
  - Latch it as sel; go to ISO next cycle; rr pointer <= sel+1 (wrap).
- ISO:
  - isolate_o[sel]=1; wait counter increments each cycle from 0.
  - If isolated_i[sel]=1, go to LOAD (takes priority over timeout in the same cycle).
  - Else if timeout_limit_i!=0 and counter==timeout_limit_i-1, go to TIMEOUT.
  - Counter saturates; it never wraps.
- LOAD (1 cycle):
  - isolate_o[sel]=1; imtu_abort_o[sel]=1.
  - All four staged slices of sel are copied to the active outputs at the end of the cycle.
  - Staged values are sampled in this cycle only. Slices of other managers are untouched.
  - Go to RELEASE.
- TIMEOUT (1 cycle): isolate_o[sel]=0; timeout_o[sel] set; go to RELEASE.
- RELEASE:
  - isolate_o[sel]=0.
  - When isolated_i[sel]=0, go to IDLE. done_o[sel] pulses in that exit cycle, only if the path came through LOAD.
  - No timeout applies in RELEASE.
- clear_timeout_i and a simultaneous set of the same bit: set wins.
- isolate_o and imtu_abort_o are decoded from registered state/sel (glitch-free, no input-to-output comb path except none).
- Exactly one manager is ever isolated by this block at a time; unselected managers always see isolate_o=0.
- busy_o=1 in every state except IDLE.
- Minimum latency, commit_i[m] at cycle t with isolated_i already responsive:
  - pending at t+1
  - ISO at t+2
  - LOAD at t+3 (abort pulse)
  - new config visible at t+4
  - IDLE at t+5 (done_o at t+4 if isolated_i drops immediately)

Test Plan:
- Single commit, mgr 1, isolated_i[1] follows isolate_o[1] with 1-cycle lag, staged w_budget region0=0x100 -> isolate_o[1] high 3 cycles; one imtu_abort_o[1] pulse; w_budget_o[1][0]=0x100; one done_o[1] pulse; other slices unchanged.
- commit_i=4'b1011 in one cycle, rr pointer 0 -> service order 0,1,3; each gets exactly one done_o; never two isolate_o bits high together.
- timeout_limit_i=5, isolated_i[2] stuck 0 -> isolate_o[2] high exactly 5 cycles; timeout_o[2]=1; no abort pulse; config unchanged; no done_o. Then clear_timeout_i[2] -> timeout_o[2]=0.
- timeout_limit_i=0, isolated_i[0] rises after 1000 cycles -> no timeout; LOAD occurs; done_o[0] pulses.
- commit_i[0] re-asserted during LOAD of mgr 0, staged value changed after LOAD -> second full sequence; final active value equals the later staged value.
- rst_i asserted during ISO of mgr 3 -> next cycle isolate_o=0, busy_o=0, pending=0, active config all 0.
